// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the write-back arbiter and its
// load queue.
//   WordSize  - default data width of register-file write data
//   RegAddrW  - width of a GPR address (x0..x31)
//   NumRegs   - number of architectural GPRs
//   wb_req_t  - one pending register write: destination and data
//   rdn_onehot- one-hot decode of a GPR address, used to build pend_mask
package core_pkg;

    localparam int WordSize = 32;
    localparam int RegAddrW = 5;
    localparam int NumRegs  = 32;

    typedef struct packed {
        logic [RegAddrW-1:0] rdn;
        logic [WordSize-1:0] data;
    } wb_req_t;

    function automatic logic [NumRegs-1:0] rdn_onehot(input logic [RegAddrW-1:0] rdn);
        logic [NumRegs-1:0] v;
        v      = '0;
        v[rdn] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small FIFO of pending load write-backs.
//   clk, rst        - clock, synchronous active-high reset (empties the queue)
//   i_push          - enqueue i_push_data (ignored while full)
//   i_push_data     - request to enqueue
//   i_pop           - drop the head entry (ignored while empty)
//   o_head          - oldest entry, valid while !o_empty
//   o_full/o_empty  - occupancy flags
//   o_count         - number of valid entries
//   o_entry_vld     - per-slot valid bits
//   o_entry_rdn     - per-slot destination registers, slot i at [i*RegAddrW +: RegAddrW]
// Push and pop in the same cycle are allowed; the count stays unchanged.
module wb_fifo
    import core_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  wb_req_t                       i_push_data,
    input  logic                          i_pop,
    output wb_req_t                       o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(Depth+1)-1:0]    o_count,
    output logic [Depth-1:0]              o_entry_vld,
    output logic [Depth*RegAddrW-1:0]     o_entry_rdn
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    wb_req_t           r_mem [Depth];
    logic [Depth-1:0]  r_vld;
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;

    logic              w_push;
    logic              w_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            // When both happen the queue is neither empty nor full, so
            // the two pointers address different slots.
            if (w_push) begin
                r_wr_ptr        <= next_ptr(r_wr_ptr);
                r_vld[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr        <= next_ptr(r_rd_ptr);
                r_vld[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: r_vld qualifies every slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_entry_vld = r_vld;

    always_comb begin
        o_entry_rdn = '0;
        for (int i = 0; i < Depth; i++) begin
            o_entry_rdn[i*RegAddrW +: RegAddrW] = r_mem[i].rdn;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and returning load data onto the single
// GPR write port.
//   clk, rst              - clock, synchronous active-high reset
//   alu_valid/alu_ready   - ALU result handshake (alu_ready is combinational)
//   alu_rdn/alu_data      - ALU destination and result
//   ld_valid/ld_ready     - load data handshake into the load queue
//   ld_rdn/ld_data        - load destination and data
//   wbe/rdn/rdd           - registered GPR write port, wired straight to the GPR
//   pend_mask             - bit i set while a queued load targets xi (bit 0 = 0)
// Handshake: a transfer happens in a cycle where valid && ready are both 1
// at the rising edge; ready never depends on a transfer completing that
// cycle, and an offered ALU result that is not accepted stays with the caller.
// Priority: a full queue drains first, otherwise ALU beats queued loads.
module wb_arbiter #(
    parameter int WordSize = 32,
    parameter int LdDepth  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [4:0]          alu_rdn,
    input  logic [WordSize-1:0] alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [4:0]          ld_rdn,
    input  logic [WordSize-1:0] ld_data,
    output logic                wbe,
    output logic [4:0]          rdn,
    output logic [WordSize-1:0] rdd,
    output logic [31:0]         pend_mask
);

    import core_pkg::*;

    localparam int CntW = $clog2(LdDepth + 1);

    wb_req_t                   w_ld_req;
    wb_req_t                   w_alu_req;
    wb_req_t                   w_head;
    wb_req_t                   w_win_req;
    logic                      w_full;
    logic                      w_empty;
    logic [CntW-1:0]           w_ld_count;
    logic                      w_has_room;
    logic [LdDepth-1:0]        w_entry_vld;
    logic [LdDepth*RegAddrW-1:0] w_entry_rdn;
    logic                      w_push;
    logic                      w_sel_ld;
    logic                      w_sel_alu;
    logic                      w_win;
    logic [NumRegs-1:0]        w_pend;

    logic                      r_wbe;
    logic [4:0]                r_rdn;
    logic [WordSize-1:0]       r_rdd;

    assign w_ld_req.rdn   = ld_rdn;
    assign w_ld_req.data  = ld_data;
    assign w_alu_req.rdn  = alu_rdn;
    assign w_alu_req.data = alu_data;

    // Room is judged on the current occupancy only: a pop happening this
    // cycle does not open a slot for a push in the same cycle.
    assign w_has_room = (w_ld_count != CntW'(LdDepth));

    assign ld_ready  = !rst && w_has_room;
    assign alu_ready = !rst && alu_valid && w_has_room;
    assign w_push    = ld_valid && ld_ready;

    // A full queue would otherwise block loads forever under steady ALU
    // traffic, so it takes precedence over the ALU.
    assign w_sel_ld  = !rst && !w_empty && (w_full || !alu_valid);
    assign w_sel_alu = alu_ready;
    assign w_win     = w_sel_ld || w_sel_alu;
    assign w_win_req = w_sel_ld ? w_head : w_alu_req;

    wb_fifo #(
        .Depth (LdDepth)
    ) u_ld_q (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_ld_req),
        .i_pop       (w_sel_ld),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_ld_count),
        .o_entry_vld (w_entry_vld),
        .o_entry_rdn (w_entry_rdn)
    );

    // x0 winners are consumed but never written; rdn/rdd keep their
    // previous values whenever wbe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbe <= 1'b0;
            r_rdn <= '0;
            r_rdd <= '0;
        end else if (w_win && (w_win_req.rdn != '0)) begin
            r_wbe <= 1'b1;
            r_rdn <= w_win_req.rdn;
            r_rdd <= w_win_req.data;
        end else begin
            r_wbe <= 1'b0;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < LdDepth; i++) begin
            if (w_entry_vld[i]) begin
                w_pend = w_pend | rdn_onehot(w_entry_rdn[i*RegAddrW +: RegAddrW]);
            end
        end
        w_pend[0] = 1'b0;
    end

    assign wbe       = r_wbe;
    assign rdn       = r_rdn;
    assign rdd       = r_rdd;
    assign pend_mask = w_pend;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rdn;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rdn;
  logic [31:0] ld_data;
  logic        wbe;
  logic [4:0]  rdn;
  logic [31:0] rdd;
  logic [31:0] pend_mask;

  int n_checks;
  int n_errors;

  wb_arbiter #(
    .WordSize (32),
    .LdDepth  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rdn   (alu_rdn),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rdn    (ld_rdn),
    .ld_data   (ld_data),
    .wbe       (wbe),
    .rdn       (rdn),
    .rdd       (rdd),
    .pend_mask (pend_mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // checking
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_wbe, input logic [4:0] e_rdn,
                           input logic [31:0] e_rdd);
    check({tag, ".wbe"}, 64'(wbe), 64'(e_wbe));
    check({tag, ".rdn"}, 64'(rdn), 64'(e_rdn));
    check({tag, ".rdd"}, 64'(rdd), 64'(e_rdd));
  endtask

  task automatic check_hs(input string tag, input logic e_alu_rdy, input logic e_ld_rdy,
                          input logic [31:0] e_pend);
    check({tag, ".alu_ready"}, 64'(alu_ready), 64'(e_alu_rdy));
    check({tag, ".ld_ready"},  64'(ld_ready),  64'(e_ld_rdy));
    check({tag, ".pend_mask"}, 64'(pend_mask), 64'(e_pend));
  endtask

  // drivers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v;
    alu_rdn   = r;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] r, input logic [31:0] d);
    ld_valid = v;
    ld_rdn   = r;
    ld_data  = d;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // reset: readies forced low even with valids high
    rst = 1'b1;
    drive_alu(1'b1, 5'd1, 32'h1);
    drive_ld(1'b1, 5'd2, 32'h2);
    settle();
    check_hs("rst_hs", 1'b0, 1'b0, 32'h0);
    cyc();
    check_out("rst_out", 1'b0, 5'd0, 32'h0);
    cyc();
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_ld(1'b0, 5'd0, 32'h0);
    settle();
    check_hs("post_rst", 1'b0, 1'b1, 32'h0);
    cyc();
    check_out("post_rst_out", 1'b0, 5'd0, 32'h0);

    // ALU only
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    settle();
    check_hs("alu_hs", 1'b1, 1'b1, 32'h0);
    cyc();
    drive_alu(1'b0, 5'd0, 32'h0);
    check_out("alu_wr", 1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    check_out("alu_hold", 1'b0, 5'd5, 32'hDEADBEEF);

    // x0 write is consumed but suppressed, rdn/rdd hold
    drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
    settle();
    check("x0_ready", 64'(alu_ready), 64'd1);
    cyc();
    drive_alu(1'b0, 5'd0, 32'h0);
    check_out("x0_wr", 1'b0, 5'd5, 32'hDEADBEEF);

    // contention
    drive_ld(1'b1, 5'd3, 32'h11);
    settle();
    check("cont_ld_rdy", 64'(ld_ready), 64'd1);
    cyc();
    drive_ld(1'b1, 5'd9, 32'h99);
    drive_alu(1'b1, 5'd4, 32'h22);
    settle();
    check_hs("cont_a", 1'b1, 1'b1, 32'h0000_0008);
    cyc();
    drive_ld(1'b0, 5'd0, 32'h0);
    check_out("cont_alu1", 1'b1, 5'd4, 32'h22);
    settle();
    check_hs("cont_full", 1'b0, 1'b0, 32'h0000_0208);
    cyc();
    check_out("cont_x3", 1'b1, 5'd3, 32'h11);
    settle();
    check_hs("cont_b", 1'b1, 1'b1, 32'h0000_0200);
    cyc();
    check_out("cont_alu2", 1'b1, 5'd4, 32'h22);
    drive_alu(1'b0, 5'd0, 32'h0);
    cyc();
    check_out("cont_x9", 1'b1, 5'd9, 32'h99);
    settle();
    check("cont_empty", 64'(pend_mask), 64'h0);
    cyc();
    check_out("cont_idle", 1'b0, 5'd9, 32'h99);

    // queue full with ALU held
    drive_alu(1'b1, 5'd10, 32'hA0);
    drive_ld(1'b1, 5'd6, 32'h66);
    cyc();
    check_out("qf_alu1", 1'b1, 5'd10, 32'hA0);
    drive_ld(1'b1, 5'd7, 32'h77);
    cyc();
    check_out("qf_alu2", 1'b1, 5'd10, 32'hA0);
    drive_ld(1'b0, 5'd0, 32'h0);
    settle();
    check_hs("qf_full", 1'b0, 1'b0, 32'h0000_00C0);
    cyc();
    check_out("qf_x6", 1'b1, 5'd6, 32'h66);
    drive_alu(1'b0, 5'd0, 32'h0);
    settle();
    check("qf_pend7", 64'(pend_mask), 64'h0000_0080);
    cyc();
    check_out("qf_x7", 1'b1, 5'd7, 32'h77);

    // simultaneous push/pop at count=1
    drive_ld(1'b1, 5'd12, 32'hC1);
    cyc();
    check_out("pp_idle", 1'b0, 5'd7, 32'h77);
    drive_ld(1'b1, 5'd13, 32'hD2);
    settle();
    check_hs("pp_hs", 1'b0, 1'b1, 32'h0000_1000);
    cyc();
    drive_ld(1'b0, 5'd0, 32'h0);
    check_out("pp_x12", 1'b1, 5'd12, 32'hC1);
    settle();
    check_hs("pp_cnt1", 1'b0, 1'b1, 32'h0000_2000);
    cyc();
    check_out("pp_x13", 1'b1, 5'd13, 32'hD2);
    settle();
    check("pp_empty", 64'(pend_mask), 64'h0);

    // reset with two queued loads
    drive_alu(1'b1, 5'd20, 32'h2020);
    drive_ld(1'b1, 5'd14, 32'hE1);
    cyc();
    check_out("rq_alu1", 1'b1, 5'd20, 32'h2020);
    drive_ld(1'b1, 5'd15, 32'hF1);
    cyc();
    check_out("rq_alu2", 1'b1, 5'd20, 32'h2020);
    drive_ld(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    settle();
    check_hs("rq_rst_hs", 1'b0, 1'b0, 32'h0000_C000);
    cyc();
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    check_out("rq_rst_out", 1'b0, 5'd0, 32'h0);
    settle();
    check_hs("rq_after", 1'b0, 1'b1, 32'h0);
    cyc();
    check_out("rq_nostale1", 1'b0, 5'd0, 32'h0);
    cyc();
    check_out("rq_nostale2", 1'b0, 5'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
